lcd_result_display: RTL and testbench
=====================================

// Module: lcd_result_display
// PURPOSE
//  Parametrised HD44780 (8-bit bus) display sequencer for the Mini-CPU SHOW stage.
//  - On a start pulse it latches opcode, register index and result.
//  - It converts the result to signed decimal with a sequential double-dabble.
//  - It then drives one full two-line frame: line 1 = mnemonic + register, line 2 = sign + magnitude.
//  - It replaces free-running, state-gated LCD writing with a start/busy/done handshake and configurable timing/width.
// PARAMETERS
//  RESULT_W         16     result width, 2..32
//  DIGITS           5      decimal digits shown; must be >= ceil(RESULT_W*log10(2)), <= 15
//  SIGNED           1      1: result is two's complement, show sign + |value|; 0: unsigned, sign char '+'
//  EN_CYCLES        50000  clk cycles EN high, and again EN low, per LCD transfer (>=1)
//  CLR_WAIT_CYCLES  100000 extra idle cycles after commands 0x01 and 0x02
// PORTS
//  clk       in   1         system clock
//  rst       in   1         asynchronous, active-high reset
//  start     in   1         1-cycle request; sampled only when busy=0
//  opcode    in   3         000 LOAD, 001 ADD, 010 ADDI, 011 SUB, 100 SUBI, 101 MUL, 110 CLEAR, 111 DISPLAY
//  reg_idx   in   4         destination register number shown on line 1
//  result    in   RESULT_W  value shown on line 2
//  busy      out  1         high from the cycle after start is accepted until done
//  done      out  1         1-cycle pulse when the frame completes
//  lcd_en    out  1         LCD E strobe
//  lcd_rw    out  1         tied 0 (write only)
//  lcd_rs    out  1         0 = command, 1 = character
//  lcd_data  out  8         LCD DB7..DB0
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; all counters 0. Reset acts mid-transfer as well, dropping lcd_en immediately.
//  Clocking: one clock domain. Every register is async-reset on rst and clocked on posedge clk.
//  Accept: start=1 while IDLE latches opcode, reg_idx and result. busy rises the next cycle.
//    start is ignored while busy=1.
//  LOAD: no LCD activity. Goes IDLE->DONE; done pulses 2 cycles after start, busy high for 1 cycle.
//  FSM states: IDLE -> CONV -> XFER <-> WAIT -> DONE -> IDLE.
//  CONV:
//    - If SIGNED and result MSB=1, magnitude = -result (width RESULT_W+1, so the most negative value is exact).
//    - Double-dabble runs one bit per cycle: exactly RESULT_W cycles, DIGITS BCD nibbles.
//  XFER, one transfer:
//    - lcd_rs/lcd_data are set in the first cycle and held stable for 2*EN_CYCLES cycles.
//    - lcd_en=1 for the first EN_CYCLES cycles, then 0 for EN_CYCLES cycles.
//  WAIT: entered only after 0x01/0x02, for CLR_WAIT_CYCLES cycles with lcd_en=0. Then the next transfer starts.
//  Transfer list, index 0..N-1, advanced after each full transfer:
//    - Init (rs=0): 0x38, 0x0C, 0x01, 0x02, 0x06.
//    - CLEAR opcode: init, then 'C','L','E','A','R' (rs=1); N=10.
//    - Other opcodes, line 1 (16 chars):
//      - 4-char mnemonic: "ADD ", "ADDI", "SUB ", "SUBI", "MUL ", "DSPL".
//      - 6 spaces, '['.
//      - reg_idx[3]..reg_idx[0] each as ASCII '0'/'1'.
//      - ']'.
//    - Then 0xC0 (rs=0).
//    - Line 2: (15-DIGITS) spaces, sign ('+' or '-'; '-' only if SIGNED and negative), DIGITS digits MSD first as 0x30+bcd.
//      Leading zeros are shown. N=5+16+1+16=38.
//  Completion: after the last transfer's EN-low phase, go to DONE. done=1 for one cycle, busy drops in the same cycle.
//    Outputs hold their last values; lcd_en=0.
//  Latency (non-LOAD): 1 + RESULT_W + N*2*EN_CYCLES + 2*CLR_WAIT_CYCLES cycles from start to done, +/-1.
//  Inputs may change freely while busy; only latched copies are used.
// TESTING
//  (bench: EN_CYCLES=2, CLR_WAIT_CYCLES=3, RESULT_W=16, DIGITS=5, SIGNED=1)
//  1 ADD, reg_idx=4'b0101, result=16'd1234
//      -> line1 "ADD       [0101]", then 0xC0, line2 "          +01234"; done after 38 transfers.
//  2 SUBI, result=16'hFFFF
//      -> line1 starts "SUBI"; line2 ends "-00001".
//  3 MUL, result=16'h8000
//      -> line2 ends "-32768"; with SIGNED=0, result=16'hFFFF -> "+65535".
//  4 CLEAR
//      -> exactly 0x38,0x0C,0x01,0x02,0x06,'C','L','E','A','R'; 3 idle cycles after 0x01 and after 0x02.
//  5 LOAD
//      -> no lcd_en edge, done 2 cycles after start; a second start while busy is ignored
//         (exactly one done per accepted start).
//  6 Assert rst during an EN-high phase
//      -> lcd_en=0, busy=0 at once; a new start after release produces a full correct frame.

Source files
------------

// File: rtl/lcd_result_display.sv
// HD44780 (8-bit bus) frame sequencer: latches opcode/register/result on start, converts the
// result to sign + decimal magnitude, then writes one two-line frame under start/busy/done.
module lcd_result_display #(
   parameter int unsigned RESULT_W        = 16,
   parameter int unsigned DIGITS          = 5,
   parameter bit          SIGNED          = 1'b1,
   parameter int unsigned EN_CYCLES       = 50000,
   parameter int unsigned CLR_WAIT_CYCLES = 100000
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_start,
   input  logic [2:0]          i_opcode,
   input  logic [3:0]          i_reg_idx,
   input  logic [RESULT_W-1:0] i_result,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_lcd_en,
   output logic                o_lcd_rw,
   output logic                o_lcd_rs,
   output logic [7:0]          o_lcd_data
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_CONV = 3'd1;
   localparam logic [2:0] ST_XFER = 3'd2;
   localparam logic [2:0] ST_WAIT = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   localparam logic [2:0] OP_LOAD  = 3'b000;
   localparam logic [2:0] OP_CLEAR = 3'b110;

   localparam int unsigned BCD_W    = 4 * DIGITS;
   localparam int          SIGN_IDX = 22 + 15 - int'(DIGITS);

   logic [2:0]          r_state;
   logic [2:0]          r_op;
   logic [3:0]          r_reg;
   logic                r_neg;
   logic [RESULT_W-1:0] r_bin;
   logic [BCD_W-1:0]    r_bcd;
   logic [31:0]         r_cnt;
   logic [5:0]          r_idx;
   logic                r_busy;
   logic                r_done;
   logic                r_lcd_en;
   logic                r_lcd_rs;
   logic [7:0]          r_lcd_data;

   logic                w_neg_in;
   logic [RESULT_W-1:0] w_mag;
   logic [BCD_W-1:0]    w_bcd_adj;
   logic [5:0]          w_load_idx;
   logic [5:0]          w_last;
   logic                w_is_clr;
   logic [31:0]         w_mnem;
   logic                w_rs;
   logic [7:0]          w_data;

   // Magnitude fits in RESULT_W unsigned bits, so the most negative value converts exactly.
   assign w_neg_in   = SIGNED && i_result[RESULT_W-1];
   assign w_mag      = w_neg_in ? ({RESULT_W{1'b0}} - i_result) : i_result;
   assign w_load_idx = (r_state == ST_CONV) ? 6'd0 : r_idx + 6'd1;
   assign w_last     = (r_op == OP_CLEAR) ? 6'd9 : 6'd37;
   assign w_is_clr   = !r_lcd_rs && ((r_lcd_data == 8'h01) || (r_lcd_data == 8'h02));

   always_comb begin
      w_bcd_adj = r_bcd;
      for (int n = 0; n < int'(DIGITS); n++) begin
         if (r_bcd[4*n +: 4] >= 4'd5) w_bcd_adj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
      end
   end

   always_comb begin
      case (r_op)
         3'b001:  w_mnem = "ADD ";
         3'b010:  w_mnem = "ADDI";
         3'b011:  w_mnem = "SUB ";
         3'b100:  w_mnem = "SUBI";
         3'b101:  w_mnem = "MUL ";
         default: w_mnem = "DSPL";
      endcase
   end

   // Character/command for transfer w_load_idx, i.e. the one loaded on this edge.
   always_comb begin
      int i;
      int k;
      logic [BCD_W-1:0] sh;
      i      = int'(w_load_idx);
      k      = 0;
      sh     = '0;
      w_rs   = 1'b1;
      w_data = 8'h20;
      if (i < 5) begin
         w_rs = 1'b0;
         case (i)
            0:       w_data = 8'h38;
            1:       w_data = 8'h0C;
            2:       w_data = 8'h01;
            3:       w_data = 8'h02;
            default: w_data = 8'h06;
         endcase
      end else if (r_op == OP_CLEAR) begin
         case (i)
            5:       w_data = "C";
            6:       w_data = "L";
            7:       w_data = "E";
            8:       w_data = "A";
            default: w_data = "R";
         endcase
      end else if (i < 9) begin
         w_data = w_mnem[8*(8-i) +: 8];
      end else if (i == 15) begin
         w_data = "[";
      end else if ((i > 15) && (i < 20)) begin
         w_data = {7'b0011000, r_reg[2'(19 - i)]};
      end else if (i == 20) begin
         w_data = "]";
      end else if (i == 21) begin
         w_rs   = 1'b0;
         w_data = 8'hC0;
      end else if (i == SIGN_IDX) begin
         w_data = r_neg ? "-" : "+";
      end else if ((i > SIGN_IDX) && (i < 38)) begin
         k      = i - SIGN_IDX - 1;
         sh     = r_bcd >> (4 * (int'(DIGITS) - 1 - k));
         w_data = {4'h3, sh[3:0]};
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_op       <= '0;
         r_reg      <= '0;
         r_neg      <= 1'b0;
         r_bin      <= '0;
         r_bcd      <= '0;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_lcd_en   <= 1'b0;
         r_lcd_rs   <= 1'b0;
         r_lcd_data <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_op    <= i_opcode;
                  r_reg   <= i_reg_idx;
                  r_neg   <= w_neg_in;
                  r_bin   <= w_mag;
                  r_bcd   <= '0;
                  r_cnt   <= '0;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= (i_opcode == OP_LOAD) ? ST_DONE : ST_CONV;
               end
            end
            ST_CONV: begin
               r_bin <= r_bin << 1;
               r_bcd <= {w_bcd_adj[BCD_W-2:0], r_bin[RESULT_W-1]};
               if (r_cnt == RESULT_W - 1) begin
                  r_cnt      <= '0;
                  r_idx      <= w_load_idx;
                  r_lcd_rs   <= w_rs;
                  r_lcd_data <= w_data;
                  r_lcd_en   <= 1'b1;
                  r_state    <= ST_XFER;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            ST_XFER: begin
               r_cnt <= r_cnt + 32'd1;
               if (r_cnt == EN_CYCLES - 1) r_lcd_en <= 1'b0;
               if (r_cnt == 2 * EN_CYCLES - 1) begin
                  r_cnt <= '0;
                  if (w_is_clr) begin
                     r_state <= ST_WAIT;
                  end else if (r_idx == w_last) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_idx      <= w_load_idx;
                     r_lcd_rs   <= w_rs;
                     r_lcd_data <= w_data;
                     r_lcd_en   <= 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               if (r_cnt == CLR_WAIT_CYCLES - 1) begin
                  r_cnt      <= '0;
                  r_idx      <= w_load_idx;
                  r_lcd_rs   <= w_rs;
                  r_lcd_data <= w_data;
                  r_lcd_en   <= 1'b1;
                  r_state    <= ST_XFER;
               end else begin
                  r_cnt <= r_cnt + 32'd1;
               end
            end
            ST_DONE: begin
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
               r_lcd_en <= 1'b0;
               r_state  <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_lcd_en   = r_lcd_en;
   assign o_lcd_rw   = 1'b0;
   assign o_lcd_rs   = r_lcd_rs;
   assign o_lcd_data = r_lcd_data;

endmodule

// File: tb/tb_lcd_result_display.sv
// Scoreboard bench for lcd_result_display: expected transfers are queued at stimulus time and
// popped on every rising LCD E strobe; a second instance covers the unsigned configuration.
module tb_lcd_result_display;

   localparam int EN_C  = 2;
   localparam int CLR_C = 3;
   localparam int RW    = 16;
   localparam int DG    = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_s, start_u;
   logic [2:0]  op;
   logic [3:0]  ridx;
   logic [15:0] res;
   logic        sel;

   logic busy_s, done_s, en_s, rw_s, rs_s;
   logic busy_u, done_u, en_u, rw_u, rs_u;
   logic [7:0] data_s, data_u;

   logic m_busy, m_done, m_en, m_rs;
   logic [7:0] m_data;

   int n_cmp = 0;
   int n_err = 0;
   int n_done = 0;
   int n_xfer = 0;
   int n_unexp = 0;

   logic [8:0] q_exp[$];

   always #5 clk = ~clk;

   lcd_result_display #(
      .RESULT_W(RW), .DIGITS(DG), .SIGNED(1'b1), .EN_CYCLES(EN_C), .CLR_WAIT_CYCLES(CLR_C)
   ) u_dut (
      .i_clk(clk), .i_rst(rst), .i_start(start_s), .i_opcode(op), .i_reg_idx(ridx),
      .i_result(res), .o_busy(busy_s), .o_done(done_s), .o_lcd_en(en_s), .o_lcd_rw(rw_s),
      .o_lcd_rs(rs_s), .o_lcd_data(data_s)
   );

   lcd_result_display #(
      .RESULT_W(RW), .DIGITS(DG), .SIGNED(1'b0), .EN_CYCLES(EN_C), .CLR_WAIT_CYCLES(CLR_C)
   ) u_dut_u (
      .i_clk(clk), .i_rst(rst), .i_start(start_u), .i_opcode(op), .i_reg_idx(ridx),
      .i_result(res), .o_busy(busy_u), .o_done(done_u), .o_lcd_en(en_u), .o_lcd_rw(rw_u),
      .o_lcd_rs(rs_u), .o_lcd_data(data_u)
   );

   assign m_busy = sel ? busy_u : busy_s;
   assign m_done = sel ? done_u : done_s;
   assign m_en   = sel ? en_u : en_s;
   assign m_rs   = sel ? rs_u : rs_s;
   assign m_data = sel ? data_u : data_s;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push(input logic rs, input logic [7:0] d);
      q_exp.push_back({rs, d});
   endtask

   // Reference frame built from the opcode table and integer decimal arithmetic.
   task automatic push_frame(input logic [2:0] o, input logic [3:0] r, input logic [15:0] v,
                             input bit sgn);
      string mn;
      string clr;
      int    mag;
      int    p;
      bit    neg;
      if (o == 3'b000) return;
      push(1'b0, 8'h38); push(1'b0, 8'h0C); push(1'b0, 8'h01);
      push(1'b0, 8'h02); push(1'b0, 8'h06);
      if (o == 3'b110) begin
         clr = "CLEAR";
         for (int i = 0; i < 5; i++) push(1'b1, clr[i]);
         return;
      end
      case (o)
         3'b001:  mn = "ADD ";
         3'b010:  mn = "ADDI";
         3'b011:  mn = "SUB ";
         3'b100:  mn = "SUBI";
         3'b101:  mn = "MUL ";
         default: mn = "DSPL";
      endcase
      for (int i = 0; i < 4; i++) push(1'b1, mn[i]);
      repeat (6) push(1'b1, 8'h20);
      push(1'b1, 8'h5B);
      for (int i = 3; i >= 0; i--) push(1'b1, r[i] ? 8'h31 : 8'h30);
      push(1'b1, 8'h5D);
      push(1'b0, 8'hC0);
      repeat (15 - DG) push(1'b1, 8'h20);
      neg = sgn && v[15];
      mag = neg ? (65536 - int'(v)) : int'(v);
      push(1'b1, neg ? 8'h2D : 8'h2B);
      for (int k = DG - 1; k >= 0; k--) begin
         p = 1;
         repeat (k) p = p * 10;
         push(1'b1, 8'h30 + 8'((mag / p) % 10));
      end
   endtask

   // Monitor: every rising E pops one expected transfer; also checks E spacing and data hold.
   initial begin
      bit         prev_en;
      bit         have_prev;
      logic [8:0] prev_item;
      logic [8:0] cur;
      int         gap;
      prev_en   = 1'b0;
      have_prev = 1'b0;
      prev_item = '0;
      gap       = 0;
      forever begin
         @(negedge clk);
         if (m_done) n_done++;
         if (!m_busy) have_prev = 1'b0;
         gap++;
         if (m_en && !prev_en) begin
            n_xfer++;
            if (q_exp.size() == 0) begin
               n_unexp++;
            end else begin
               cur = q_exp.pop_front();
               chk("xfer_char", 32'({m_rs, m_data}), 32'(cur));
               if (have_prev)
                  chk("xfer_gap", 32'(gap),
                      32'(((prev_item == 9'h001) || (prev_item == 9'h002)) ?
                          2 * EN_C + CLR_C : 2 * EN_C));
               prev_item = cur;
               have_prev = 1'b1;
            end
            gap = 0;
         end
         if (!m_en && prev_en && have_prev)
            chk("xfer_hold", 32'({m_rs, m_data}), 32'(prev_item));
         prev_en = m_en;
      end
   end

   task automatic run_frame(input bit s, input logic [2:0] o, input logic [3:0] r,
                            input logic [15:0] v);
      int cyc;
      int inj;
      int n;
      int lat;
      int d0;
      int x0;
      logic busy1;
      sel = s;
      q_exp.delete();
      push_frame(o, r, v, !s);
      n   = q_exp.size();
      lat = (o == 3'b000) ? 2 : 1 + RW + n * 2 * EN_C + 2 * CLR_C;
      inj = (o == 3'b000) ? 1 : 3;
      @(negedge clk);
      op = o; ridx = r; res = v;
      if (s) start_u = 1'b1; else start_s = 1'b1;
      d0 = n_done;
      x0 = n_xfer;
      @(negedge clk);
      start_s = 1'b0; start_u = 1'b0;
      op = 3'b110; ridx = ~r; res = 16'($urandom);
      cyc   = 1;
      busy1 = m_busy;
      while (!m_done && cyc < 3000) begin
         if (cyc == inj) begin
            if (s) start_u = 1'b1; else start_s = 1'b1;
         end else begin
            start_s = 1'b0; start_u = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start_s = 1'b0; start_u = 1'b0;
      chk("done_seen", 32'(m_done), 1);
      chk("busy_rise", 32'(busy1), 1);
      chk("busy_at_done", 32'(m_busy), 0);
      chk("latency_window", 32'((cyc >= lat - 1) && (cyc <= lat + 1)), 1);
      if (o == 3'b000) chk("load_latency", 32'(cyc), 2);
      repeat (6) @(negedge clk);
      chk("done_count", 32'(n_done - d0), 1);
      chk("xfer_count", 32'(n_xfer - x0), 32'(n));
      chk("queue_drained", 32'(q_exp.size()), 0);
      chk("extra_xfers", 32'(n_unexp), 0);
   endtask

   initial begin
      int cyc;
      rst = 1'b1; start_s = 1'b0; start_u = 1'b0;
      op = '0; ridx = '0; res = '0; sel = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy_s), 0);
      chk("rst_done", 32'(done_s), 0);
      chk("rst_en", 32'(en_s), 0);
      chk("rst_rw", 32'(rw_s), 0);
      chk("rst_rs", 32'(rs_s), 0);
      chk("rst_data", 32'(data_s), 0);
      rst = 1'b0;

      run_frame(1'b0, 3'b001, 4'b0101, 16'd1234);
      run_frame(1'b0, 3'b100, 4'b0011, 16'hFFFF);
      run_frame(1'b0, 3'b101, 4'b1000, 16'h8000);
      run_frame(1'b1, 3'b111, 4'b1111, 16'hFFFF);
      run_frame(1'b0, 3'b110, 4'b0010, 16'h0042);
      run_frame(1'b0, 3'b000, 4'b0001, 16'h0007);
      chk("rw_idle", 32'(rw_u), 0);

      // Abort a frame with reset while E is high, then run a clean frame.
      sel = 1'b0;
      q_exp.delete();
      push_frame(3'b001, 4'b1100, 16'd77, 1'b1);
      @(negedge clk);
      op = 3'b001; ridx = 4'b1100; res = 16'd77; start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      cyc = 0;
      while (!en_s && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("en_reached", 32'(en_s), 1);
      rst = 1'b1;
      #1;
      chk("rst_mid_en", 32'(en_s), 0);
      chk("rst_mid_busy", 32'(busy_s), 0);
      chk("rst_mid_data", 32'(data_s), 0);
      @(negedge clk);
      rst = 1'b0;
      q_exp.delete();
      run_frame(1'b0, 3'b011, 4'b1010, 16'hFFFB);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
